// File: rtl/cpu_defs.sv
// cpu_defs: shared CPU constants, step controller defaults and button FSM encoding.
package cpu_defs;
   localparam int WORD_SIZE = 8;
   localparam int unsigned DEF_DEBOUNCE_CYCLES = 16;
   localparam int unsigned DEF_AUTO_PERIOD = 50000000;
   typedef enum logic [1:0] {IDLE, PRESS_WAIT, PRESSED, RELEASE_WAIT} btn_state_t;
endpackage

// File: rtl/sync2.sv
// sync2: two-flop synchroniser for one asynchronous input.
module sync2 (
   input  logic clk,
   input  logic rst,
   input  logic d,
   output logic q
);
   logic s1;
   always_ff @(posedge clk or posedge rst)
      if (rst) {q, s1} <= 2'b00;
      else {q, s1} <= {s1, d};
endmodule

// File: rtl/step_ctrl.sv
// step_ctrl: debounced manual / free-running auto step pulse generator.
// Define STEP_COUNT_EN to build the stepCount pulse counter; otherwise stepCount is tied to 0.
module step_ctrl import cpu_defs::*; #(
   parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
   parameter int unsigned AUTO_PERIOD = DEF_AUTO_PERIOD
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       isAuto,
   input  logic       nextStage,
   output logic       step,
   output logic       autoMode,
   output logic [7:0] stepCount
);
   localparam logic [15:0] DLAST = 16'(DEBOUNCE_CYCLES - 1);
   localparam logic [31:0] PLAST = 32'(AUTO_PERIOD - 1);
   logic auto_s, btn, press, step_nxt;
   logic [15:0] cnt, cnt_nxt;
   logic [31:0] presc;
   btn_state_t state, state_nxt;
   sync2 u_sync_auto (.clk(clk), .rst(rst), .d(isAuto), .q(auto_s));
   sync2 u_sync_btn (.clk(clk), .rst(rst), .d(nextStage), .q(btn));
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         state <= IDLE;
         cnt <= '0;
      end else begin
         state <= state_nxt;
         cnt <= cnt_nxt;
      end
   always_comb begin
      state_nxt = state;
      cnt_nxt = cnt;
      press = 1'b0;
      case (state)
         IDLE:
            if (btn) begin
               state_nxt = PRESS_WAIT;
               cnt_nxt = '0;
            end
         PRESS_WAIT:
            if (!btn) state_nxt = IDLE;
            else if (cnt == DLAST) begin
               state_nxt = PRESSED;
               press = 1'b1;
            end else cnt_nxt = cnt + 16'd1;
         PRESSED:
            if (!btn) begin
               state_nxt = RELEASE_WAIT;
               cnt_nxt = '0;
            end
         RELEASE_WAIT:
            if (btn) state_nxt = PRESSED;
            else if (cnt == DLAST) state_nxt = IDLE;
            else cnt_nxt = cnt + 16'd1;
         default: state_nxt = IDLE;
      endcase
   end
   // The mode register gates both sources, so a tick pending when it falls is dropped.
   assign step_nxt = (autoMode ? presc == PLAST : press) && !step;
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         autoMode <= 1'b0;
         presc <= '0;
         step <= 1'b0;
      end else begin
         autoMode <= auto_s;
         presc <= (!autoMode || presc == PLAST) ? '0 : presc + 32'd1;
         step <= step_nxt;
      end
`ifdef STEP_COUNT_EN
   logic [7:0] count;
   always_ff @(posedge clk or posedge rst)
      if (rst) count <= '0;
      else if (step) count <= count + 8'd1;
   assign stepCount = count;
`else
   assign stepCount = '0;
`endif
endmodule

// File: tb/tb_step_ctrl.sv
// tb_step_ctrl: scoreboard bench for step_ctrl with DEBOUNCE_CYCLES=4, AUTO_PERIOD=10.
module tb_step_ctrl;
   logic clk = 1'b0, rst = 1'b1, isAuto = 1'b0, nextStage = 1'b0;
   logic step, autoMode;
   logic [7:0] stepCount;
   int cyc = 0, checks = 0, errors = 0, last_step = -10;
   int q[$];
   step_ctrl #(.DEBOUNCE_CYCLES(4), .AUTO_PERIOD(10)) dut (
      .clk(clk), .rst(rst), .isAuto(isAuto), .nextStage(nextStage),
      .step(step), .autoMode(autoMode), .stepCount(stepCount)
   );
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;
   function automatic int exp_cnt(input int n);
`ifdef STEP_COUNT_EN
      return n % 256;
`else
      return 0;
`endif
   endfunction
   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask
   // Monitor: every observed step must match the next expected cycle.
   always @(negedge clk)
      if (step) begin
         checks++;
         if (cyc == last_step + 1) begin
            errors++;
            $display("FAIL step_consecutive: got step at %0d after %0d", cyc, last_step);
         end
         last_step = cyc;
         if (q.size() == 0) begin
            errors++;
            $display("FAIL step_unexpected: got step at cycle %0d expected none", cyc);
         end else chk("step_cycle", cyc, q.pop_front());
      end
   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1;
      isAuto = 1'b0;
      nextStage = 1'b0;
      repeat (2) @(negedge clk);
      chk("rst_step", int'(step), 0);
      chk("rst_auto", int'(autoMode), 0);
      chk("rst_count", int'(stepCount), 0);
      rst = 1'b0;
      repeat (3) @(negedge clk);
   endtask
   task automatic press(input int hold, input int rel, input bit exp);
      if (exp) q.push_back(cyc + 7);
      nextStage = 1'b1;
      repeat (hold) @(negedge clk);
      nextStage = 1'b0;
      repeat (rel) @(negedge clk);
   endtask
   task automatic drain(input string name);
      repeat (15) @(negedge clk);
      chk(name, q.size(), 0);
      q.delete();
   endtask
   initial begin
      int c0;
      do_reset();
      press(20, 12, 1'b1);
      drain("manual_missing");
      chk("manual_count", int'(stepCount), exp_cnt(1));
      do_reset();
      for (int i = 0; i < 2; i++) begin
         nextStage = 1'b1;
         repeat (2) @(negedge clk);
         nextStage = 1'b0;
         repeat (2) @(negedge clk);
      end
      drain("bounce_missing");
      chk("bounce_count", int'(stepCount), 0);
      do_reset();
      c0 = cyc;
      for (int k = 0; k < 10; k++) q.push_back(c0 + 13 + 10 * k);
      isAuto = 1'b1;
      repeat (2) @(negedge clk);
      chk("auto_sync_lo", int'(autoMode), 0);
      @(negedge clk);
      chk("auto_sync_hi", int'(autoMode), 1);
      repeat (101) @(negedge clk);
      isAuto = 1'b0;
      drain("auto_missing");
      chk("auto_mode_off", int'(autoMode), 0);
      chk("auto_count", int'(stepCount), exp_cnt(10));
      do_reset();
      c0 = cyc;
      q.push_back(c0 + 13);
      q.push_back(c0 + 23);
      isAuto = 1'b1;
      nextStage = 1'b1;
      repeat (20) @(negedge clk);
      nextStage = 1'b0;
      repeat (5) @(negedge clk);
      isAuto = 1'b0;
      drain("autopress_missing");
      chk("autopress_count", int'(stepCount), exp_cnt(2));
      do_reset();
      nextStage = 1'b1;
      repeat (5) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      chk("midrst_step", int'(step), 0);
      rst = 1'b0;
      q.push_back(cyc + 7);
      repeat (12) @(negedge clk);
      nextStage = 1'b0;
      drain("midrst_missing");
      chk("midrst_count", int'(stepCount), exp_cnt(1));
      do_reset();
      for (int i = 0; i < 256; i++) begin
         press(9, 10, 1'b1);
         if (i == 127) chk("wrap_half", int'(stepCount), exp_cnt(128));
      end
      drain("wrap_missing");
      chk("wrap_count", int'(stepCount), exp_cnt(256));
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/step_ctrl.md
STEP_CTRL -- requirements
Module: step_ctrl

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 16, is the number of consecutive stable synchronised samples needed to accept a button edge (legal range 2..65535).
REQ-002 Parameter AUTO_PERIOD, default 50000000, is the number of clk cycles between auto-mode steps (legal range 2..2^32-1).
REQ-003 Port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 Port rst, input, 1 bit: asynchronous, active-high reset.
REQ-005 Port isAuto, input, 1 bit: asynchronous mode switch; 1 selects free-running stepping.
REQ-006 Port nextStage, input, 1 bit: asynchronous raw push-button; 1 means pressed.
REQ-007 Port step, output, 1 bit: single-cycle advance pulse consumed by the CPU stage sequencer.
REQ-008 Port autoMode, output, 1 bit: synchronised, registered copy of isAuto.
REQ-009 Port stepCount, output, 8 bits: number of step pulses issued, modulo 256.

Function
REQ-010 isAuto and nextStage shall each pass through a two-flop synchroniser before any use.
REQ-011 The button FSM shall have states IDLE, PRESS_WAIT, PRESSED and RELEASE_WAIT, with one 16-bit stability counter.
REQ-012 IDLE->PRESS_WAIT on synced button=1, with counter cleared.
REQ-013 PRESS_WAIT: counter increments while button=1; button=0 returns to IDLE; counter reaching DEBOUNCE_CYCLES-1 with button=1 moves to PRESSED.
REQ-014 PRESSED->RELEASE_WAIT on button=0, with counter cleared.
REQ-015 RELEASE_WAIT: counter increments while button=0; button=1 returns to PRESSED; counter reaching DEBOUNCE_CYCLES-1 moves to IDLE.
REQ-016 In manual mode (autoMode=0), step shall be 1 for exactly the one cycle following the PRESS_WAIT->PRESSED transition.
REQ-017 A held button shall produce exactly one step, and a bounce shorter than DEBOUNCE_CYCLES shall produce none.
REQ-018 In auto mode, a 32-bit prescaler shall count 0..AUTO_PERIOD-1 and wrap, with step=1 in the cycle after the prescaler equals AUTO_PERIOD-1.
REQ-019 The prescaler shall hold at 0 while autoMode=0, so the first auto step comes exactly AUTO_PERIOD cycles after autoMode rises.
REQ-020 In auto mode the FSM shall keep tracking the button, but its press events shall not generate step.
REQ-021 When autoMode falls, any pending auto tick shall be discarded; a button press completing in that same cycle counts as a manual step.
REQ-022 step shall never be high for two consecutive cycles.
REQ-023 stepCount shall increment by 1 in every cycle step=1 and wrap from 255 to 0.

Reset
REQ-024 While rst=1, the FSM shall be IDLE; the counter, prescaler, synchronisers, step, autoMode and stepCount shall be 0.
REQ-025 Reset asserted mid-debounce or mid-period shall abort the operation with no step emitted.
REQ-026 After rst deasserts, a button already held shall be treated as a fresh press and debounced from zero.

Configuration
REQ-027 With macro STEP_COUNT_EN defined, stepCount shall behave as in REQ-023.
REQ-028 Without STEP_COUNT_EN, stepCount shall be constant 0 and its register shall not be synthesised.

Structure
REQ-029 The FSM state encoding and default parameter constants shall live in the shared package cpu_defs, alongside WORD_SIZE.
REQ-030 The two-flop synchroniser shall be a sub-module named sync2, instantiated once per asynchronous input.

Verification (DEBOUNCE_CYCLES=4, AUTO_PERIOD=10)
REQ-031 Manual press: rst release, nextStage=1 held 20 cycles -> exactly one step, 2+4+1 cycles after assertion; stepCount=1.
REQ-032 Bounce: nextStage toggled 1,0,1,0 every 2 cycles, then 0 -> no step; stepCount=0.
REQ-033 Auto mode: isAuto=1 held 100 cycles after sync -> step pulses 10 cycles apart, first at cycle 10; stepCount=10.
REQ-034 Auto mode plus press: isAuto=1 with nextStage held 20 cycles -> step only from the prescaler, never doubled and never on consecutive cycles.
REQ-035 Reset mid-debounce: rst pulsed at 3rd stable sample with button held -> no step; a step follows 2+4+1 cycles after rst falls.
REQ-036 Wrap: 256 manual presses -> stepCount=0 (with STEP_COUNT_EN); stepCount stays 0 throughout when the macro is undefined.
